pe_in_buffer: RTL and testbench

- Per-port elastic input buffer between the NoC router outputs and a PE's μcore/functional-unit inputs.
- Each of NUM_IN NoC input channels gets a DEPTH-entry FIFO with valid/ready on both sides. This decouples NoC timing from PE firing.
- Also produces the "all enabled operands present" indication the μcore uses to fire.
- Configured per port by an enable mask; flushed by ctrl_clear.

---
 rtl/riptide_pkg.sv | 18 +
 rtl/pe_chan_fifo.sv | 87 ++++++++
 rtl/pe_in_buffer.sv | 49 ++++
 tb/tb_pe_in_buffer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riptide_pkg.sv
// Shared types and helpers for the Riptide PE datapath.
package riptide_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  typedef struct packed {
    logic  valid;
    data_t data;
  } chan_t;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pe_chan_fifo.sv
// Single-channel elastic FIFO: valid/ready on both sides, count-based full/empty,
// registered-state-only ready, no bypass from push to pop.
module pe_chan_fifo
  import riptide_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [DATA_WIDTH-1:0]        push_data_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [DATA_WIDTH-1:0]        pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_s;
  logic                  pop_s;

  // A full FIFO stays not-ready even if the consumer pops in the same cycle.
  assign push_ready_o = en_i & (count_q != FULL_CNT);
  assign pop_valid_o  = en_i & (count_q != {CNT_W{1'b0}});
  assign push_s       = push_valid_i & push_ready_o;
  assign pop_s        = pop_valid_o & pop_ready_i;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers/count define contents.
  always_ff @(posedge clk) begin
    if (push_s && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/pe_in_buffer.sv
// Per-port input buffering between NoC router outputs and the PE μcore, plus the
// "all enabled operands present" firing indication.
module pe_in_buffer
  import riptide_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = 3,
  parameter int DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ctrl_clear,
  input  logic [NUM_IN-1:0]                    cfg_port_en,
  input  logic [NUM_IN-1:0]                    noc_ivalid,
  input  logic [NUM_IN*DATA_WIDTH-1:0]         noc_in,
  output logic [NUM_IN-1:0]                    noc_oready,
  output logic [NUM_IN-1:0]                    fu_ivalid,
  output logic [NUM_IN*DATA_WIDTH-1:0]         fu_in,
  input  logic [NUM_IN-1:0]                    fu_iready,
  output logic                                 all_valid,
  output logic [NUM_IN*$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    pe_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (ctrl_clear),
      .en_i         (cfg_port_en[i]),
      .push_valid_i (noc_ivalid[i]),
      .push_ready_o (noc_oready[i]),
      .push_data_i  (noc_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop_valid_o  (fu_ivalid[i]),
      .pop_ready_i  (fu_iready[i]),
      .pop_data_o   (fu_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .count_o      (occupancy[i*OCC_W +: OCC_W])
    );
  end

  // Disabled ports never present, so only enabled ports can hold this low.
  assign all_valid = (cfg_port_en != {NUM_IN{1'b0}}) &&
                     ((fu_ivalid & cfg_port_en) == cfg_port_en);

endmodule

// File: tb/tb_pe_in_buffer.sv
// Randomised + directed bench: the driver predicts acceptance from a queue model and
// queues expected tokens; a negedge monitor checks status and pops on each handshake.
module tb_pe_in_buffer;
  import riptide_pkg::*;

  localparam int DW = 32;
  localparam int NI = 3;
  localparam int D  = 4;
  localparam int OW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ctrl_clear = 1'b0;
  logic [NI-1:0]     cfg_port_en = 3'b111;
  logic [NI-1:0]     noc_ivalid = 3'b000;
  logic [NI*DW-1:0]  noc_in = '0;
  logic [NI-1:0]     noc_oready;
  logic [NI-1:0]     fu_ivalid;
  logic [NI*DW-1:0]  fu_in;
  logic [NI-1:0]     fu_iready = 3'b000;
  logic              all_valid;
  logic [NI*OW-1:0]  occupancy;

  always #5 clk = ~clk;

  pe_in_buffer #(.DATA_WIDTH(DW), .NUM_IN(NI), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_clear(ctrl_clear), .cfg_port_en(cfg_port_en),
    .noc_ivalid(noc_ivalid), .noc_in(noc_in), .noc_oready(noc_oready),
    .fu_ivalid(fu_ivalid), .fu_in(fu_in), .fu_iready(fu_iready),
    .all_valid(all_valid), .occupancy(occupancy)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [NI][$];
  int  cur_cnt [NI];
  int  nxt_cnt [NI];
  bit  active = 1'b0;
  bit  flush_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NI*DW-1:0] pk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
    return {c, b, a};
  endfunction

  // One cycle of stimulus; the model predicts what the next clock edge does.
  task automatic step(input logic rst_v, input logic clr, input logic [NI-1:0] en,
                      input logic [NI-1:0] iv, input logic [NI-1:0] rdy,
                      input logic [NI*DW-1:0] din);
    @(posedge clk);
    #1;
    if (flush_pending) begin
      for (int i = 0; i < NI; i++) exp_q[i].delete();
      flush_pending = 1'b0;
    end
    cur_cnt = nxt_cnt;
    rst_n = rst_v;
    ctrl_clear = clr;
    cfg_port_en = en;
    noc_ivalid = iv;
    fu_iready = rdy;
    noc_in = din;
    if (!rst_v || clr) begin
      for (int i = 0; i < NI; i++) nxt_cnt[i] = 0;
      flush_pending = 1'b1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit do_pop, do_push;
        do_pop  = en[i] && (cur_cnt[i] > 0) && rdy[i];
        do_push = en[i] && (cur_cnt[i] < D) && iv[i];
        nxt_cnt[i] = cur_cnt[i] + int'(do_push) - int'(do_pop);
        if (do_push) exp_q[i].push_back(din[i*DW +: DW]);
      end
    end
    active = 1'b1;
  endtask

  // Monitor: status against the model, data against the scoreboard on each pop.
  always @(negedge clk) begin
    if (active) begin
      bit av_exp;
      av_exp = (cfg_port_en != 3'b000);
      for (int i = 0; i < NI; i++) begin
        bit en_i;
        en_i = cfg_port_en[i];
        if (en_i && cur_cnt[i] == 0) av_exp = 1'b0;
        check($sformatf("oready[%0d]", i), 64'(noc_oready[i]), 64'(en_i && cur_cnt[i] < D));
        check($sformatf("fu_ivalid[%0d]", i), 64'(fu_ivalid[i]), 64'(en_i && cur_cnt[i] > 0));
        check($sformatf("occupancy[%0d]", i), 64'(occupancy[i*OW +: OW]), 64'(cur_cnt[i]));
        if (fu_ivalid[i] === 1'b1 && fu_iready[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("pop_unexpected[%0d]", i), 64'(fu_in[i*DW +: DW]), 64'hDEAD_0000_0000);
          end else begin
            check($sformatf("fu_in[%0d]", i), 64'(fu_in[i*DW +: DW]), 64'(exp_q[i].pop_front()));
          end
        end
      end
      check("all_valid", 64'(all_valid), 64'(av_exp));
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      cur_cnt[i] = 0;
      nxt_cnt[i] = 0;
    end
    // Reset, then idle with all ports enabled.
    step(1'b0, 1'b0, 3'b111, 3'b000, 3'b000, '0);
    step(1'b0, 1'b0, 3'b111, 3'b111, 3'b111, pk(32'h1, 32'h2, 32'h3));
    step(1'b1, 1'b0, 3'b111, 3'b000, 3'b000, '0);
    step(1'b1, 1'b0, 3'b111, 3'b000, 3'b000, '0);

    // Port 0 fill to full, offer a fifth token, then drain in order.
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hA, 32'h0, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hB, 32'h0, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hC, 32'h0, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hD, 32'h0, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hE, 32'h0, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b001, 3'b000, pk(32'hE, 32'h0, 32'h0));
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 3'b111, 3'b000, 3'b001, '0);

    // Port 1 simultaneous push/pop at count 2.
    step(1'b1, 1'b0, 3'b111, 3'b010, 3'b000, pk(32'h0, 32'h11, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b010, 3'b000, pk(32'h0, 32'h22, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b010, 3'b010, pk(32'h0, 32'h55, 32'h0));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b111, 3'b000, 3'b010, '0);

    // Port 1 full with push and pop offered together: pop only.
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 3'b111, 3'b010, 3'b000, pk(32'h0, 32'h60 + 32'(k), 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b010, 3'b010, pk(32'h0, 32'h99, 32'h0));
    step(1'b1, 1'b0, 3'b111, 3'b000, 3'b000, '0);

    // Port 1 disabled, operands arrive on port 0 then port 2 three cycles later.
    step(1'b1, 1'b1, 3'b101, 3'b000, 3'b000, '0);
    step(1'b1, 1'b0, 3'b101, 3'b011, 3'b000, pk(32'h70, 32'h71, 32'h0));
    step(1'b1, 1'b0, 3'b101, 3'b000, 3'b000, '0);
    step(1'b1, 1'b0, 3'b101, 3'b000, 3'b000, '0);
    step(1'b1, 1'b0, 3'b101, 3'b110, 3'b000, pk(32'h0, 32'h72, 32'h73));
    step(1'b1, 1'b0, 3'b101, 3'b000, 3'b000, '0);
    step(1'b1, 1'b0, 3'b101, 3'b000, 3'b101, '0);
    step(1'b1, 1'b1, 3'b111, 3'b000, 3'b000, '0);

    // Random traffic wrapping pointers many times, occasional clear/disable/reset.
    for (int k = 0; k < 400; k++) begin
      logic [NI-1:0] en;
      en = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      step((k == 200) ? 1'b0 : 1'b1, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, en,
           3'($urandom), 3'($urandom), pk($urandom, $urandom, $urandom));
    end

    // Clear with tokens offered on every port; those tokens must never appear.
    step(1'b1, 1'b0, 3'b111, 3'b111, 3'b000, pk(32'hC0, 32'hC1, 32'hC2));
    step(1'b1, 1'b1, 3'b111, 3'b111, 3'b000, pk(32'hBAD0, 32'hBAD1, 32'hBAD2));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b111, 3'b000, 3'b111, '0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
